// File: rtl/up_counter_pkg.sv
`default_nettype none
// ============================================================================
// up_counter_pkg : legal parameter ranges and period helper for up_counter
// Revision 1.0
// ============================================================================
package up_counter_pkg;

    localparam int unsigned C_WIDTH_MIN = 1;
    localparam int unsigned C_WIDTH_MAX = 32;

    // Number of cycles in one count sequence from reset_val to max_val inclusive.
    function automatic int unsigned period(input int unsigned max_val,
                                           input int unsigned reset_val);
        return max_val - reset_val + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/up_counter_count_cmp.sv
`default_nettype none
// ============================================================================
// count_cmp : equality comparator used to decode terminal count
// Revision 1.0
// ============================================================================
module count_cmp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o
);

    assign eq_o = (a_i == b_i);

endmodule
`default_nettype wire

// File: rtl/up_counter.sv
`default_nettype none
// ============================================================================
// up_counter : free-running modulo up-counter with terminal count and wrap pulse
// Revision 1.0
// ============================================================================
module up_counter
    import up_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX       = (1 << WIDTH) - 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // 64-bit compare so WIDTH = 32 does not overflow the range check.
    if ((WIDTH < C_WIDTH_MIN) || (WIDTH > C_WIDTH_MAX) || (MAX < 1) ||
        (longint'(MAX) >= (longint'(1) << WIDTH)) || (RESET_VAL > MAX)) begin : g_bad_params
        $error("up_counter: illegal WIDTH/MAX/RESET_VAL combination");
    end

    localparam logic [WIDTH-1:0] C_MAX       = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_RESET_VAL = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             tc_w;

    count_cmp #(
        .WIDTH (WIDTH)
    ) u_tc_cmp (
        .a_i  (count_q),
        .b_i  (C_MAX),
        .eq_o (tc_w)
    );

    // The terminal compare precedes the increment, so count never overflows.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        wrap_d  = 1'b0;
        if (tc_w) begin
            count_d = C_RESET_VAL;
            wrap_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= C_RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_w;
    assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_up_counter.sv
`default_nettype none
// ============================================================================
// tb_up_counter : scoreboard bench for default, offset and degenerate counters
// Revision 1.0
// ============================================================================
module tb_up_counter;
    import up_counter_pkg::*;

    typedef struct packed {
        logic [31:0] cnt;
        logic        tc;
        logic        wrap;
    } obs_t;

    localparam int unsigned MX [3] = '{15, 9, 5};
    localparam int unsigned RV [3] = '{0, 2, 5};

    logic       clk = 1'b0;
    logic [2:0] rst_n = 3'b000;
    logic [3:0] cnt0, cnt1, cnt2;
    logic       tc0, tc1, tc2;
    logic       wrap0, wrap1, wrap2;

    logic [31:0] m_cnt  [3];
    logic        m_wrap [3];
    obs_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    up_counter u_dut0 (
        .clk(clk), .rst(rst_n[0]), .count(cnt0), .tc(tc0), .wrap(wrap0)
    );
    up_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(2)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .count(cnt1), .tc(tc1), .wrap(wrap1)
    );
    up_counter #(.WIDTH(4), .MAX(5), .RESET_VAL(5)) u_dut2 (
        .clk(clk), .rst(rst_n[2]), .count(cnt2), .tc(tc2), .wrap(wrap2)
    );

    function automatic obs_t observe(input int d);
        obs_t o;
        case (d)
            0:       o = '{{28'd0, cnt0}, tc0, wrap0};
            1:       o = '{{28'd0, cnt1}, tc1, wrap1};
            default: o = '{{28'd0, cnt2}, tc2, wrap2};
        endcase
        return o;
    endfunction

    // Drive rst for one DUT, advance every model one edge, optionally push the
    // expected output of DUT d, then step past the edge.
    task automatic drive(input int d, input logic r, input bit score);
        rst_n[d] = r;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                m_cnt[k]  = RV[k];
                m_wrap[k] = 1'b0;
            end else if (m_cnt[k] == MX[k]) begin
                m_cnt[k]  = RV[k];
                m_wrap[k] = 1'b1;
            end else begin
                m_cnt[k]  = m_cnt[k] + 1;
                m_wrap[k] = 1'b0;
            end
        end
        if (score)
            sb.push_back('{m_cnt[d], (m_cnt[d] == MX[d]), m_wrap[d]});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, a;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b0, 1'b1);
            e = sb.pop_front(); a = observe(0); checks++;
            if (a !== e || a.cnt !== 32'd0)
                $display("FAIL reset_hold cyc%0d: got cnt=%0d tc=%b wrap=%b want cnt=%0d tc=%b wrap=%b",
                         i, a.cnt, a.tc, a.wrap, e.cnt, e.tc, e.wrap);
            if (a !== e || a.cnt !== 32'd0) errors++;
        end
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1'b1, 1'b1);
            e = sb.pop_front(); a = observe(0); checks++;
            if (a !== e || a.cnt !== 32'(i)) begin
                errors++;
                $display("FAIL reset_release step%0d: got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                         i, a.cnt, a.wrap, i, e.wrap);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t e, a;
        int   n_tc, n_wrap;
        logic [31:0] want [4] = '{14, 15, 0, 1};
        for (int i = 0; i < 40 && m_cnt[0] != 13; i++) drive(0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b1);
            e = sb.pop_front(); a = observe(0); checks++;
            if (a !== e || a.cnt !== want[i] || a.tc !== (want[i] == 15) || a.wrap !== (want[i] == 0)) begin
                errors++;
                $display("FAIL wrap_seq step%0d: got cnt=%0d tc=%b wrap=%b want cnt=%0d tc=%b wrap=%b",
                         i, a.cnt, a.tc, a.wrap, want[i], (want[i] == 15), (want[i] == 0));
            end
        end
        n_tc = 0; n_wrap = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b1);
            e = sb.pop_front(); a = observe(0);
            if (a.tc === 1'b1) n_tc++;
            if (a.wrap === 1'b1) n_wrap++;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL wrap_period cyc%0d: got cnt=%0d tc=%b wrap=%b want cnt=%0d tc=%b wrap=%b",
                         i, a.cnt, a.tc, a.wrap, e.cnt, e.tc, e.wrap);
            end
        end
        checks++;
        if (n_tc != 1 || n_wrap != 1) begin
            errors++;
            $display("FAIL pulses_per_period: got tc=%0d wrap=%0d want 1 1", n_tc, n_wrap);
        end
    endtask

    task automatic test_mid_reset();
        obs_t e, a;
        for (int i = 0; i < 40 && m_cnt[0] != 7; i++) drive(0, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b1);
        e = sb.pop_front(); a = observe(0); checks++;
        if (a !== e || a.cnt !== 32'd0 || a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d wrap=%b want cnt=0 wrap=0", a.cnt, a.wrap);
        end
        drive(0, 1'b1, 1'b1);
        e = sb.pop_front(); a = observe(0); checks++;
        if (a !== e || a.cnt !== 32'd1 || a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: got cnt=%0d wrap=%b want cnt=1 wrap=0", a.cnt, a.wrap);
        end
    endtask

    task automatic test_reset_at_max();
        obs_t e, a;
        for (int i = 0; i < 40 && m_cnt[0] != 15; i++) drive(0, 1'b1, 1'b0);
        checks++;
        if (tc0 !== 1'b1 || cnt0 !== 4'd15) begin
            errors++;
            $display("FAIL tc_at_max: got cnt=%0d tc=%b want cnt=15 tc=1", cnt0, tc0);
        end
        drive(0, 1'b0, 1'b1);
        e = sb.pop_front(); a = observe(0); checks++;
        if (a !== e || a.cnt !== 32'd0 || a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_wrap: got cnt=%0d wrap=%b want cnt=0 wrap=0", a.cnt, a.wrap);
        end
        drive(0, 1'b1, 1'b0);
    endtask

    task automatic test_offset();
        obs_t e, a;
        int   last_wrap, gap;
        drive(1, 1'b0, 1'b1);
        e = sb.pop_front(); a = observe(1); checks++;
        if (a !== e || a.cnt !== 32'd2) begin
            errors++;
            $display("FAIL offset_reset: got cnt=%0d tc=%b wrap=%b want cnt=2 tc=0 wrap=0", a.cnt, a.tc, a.wrap);
        end
        last_wrap = -1; gap = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1'b1, 1'b1);
            e = sb.pop_front(); a = observe(1); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL offset_seq cyc%0d: got cnt=%0d tc=%b wrap=%b want cnt=%0d tc=%b wrap=%b",
                         i, a.cnt, a.tc, a.wrap, e.cnt, e.tc, e.wrap);
            end
            if (a.wrap === 1'b1) begin
                if (last_wrap >= 0) gap = i - last_wrap;
                last_wrap = i;
            end
        end
        checks++;
        if (gap != int'(period(9, 2)) || gap != 8) begin
            errors++;
            $display("FAIL offset_period: got %0d want 8", gap);
        end
    endtask

    task automatic test_degenerate();
        obs_t e, a;
        drive(2, 1'b0, 1'b1);
        e = sb.pop_front(); a = observe(2); checks++;
        if (a !== e || a.cnt !== 32'd5 || a.tc !== 1'b1 || a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL degen_reset: got cnt=%0d tc=%b wrap=%b want cnt=5 tc=1 wrap=0", a.cnt, a.tc, a.wrap);
        end
        for (int i = 0; i < 5; i++) begin
            drive(2, 1'b1, 1'b1);
            e = sb.pop_front(); a = observe(2); checks++;
            if (a !== e || a.cnt !== 32'd5 || a.tc !== 1'b1 || a.wrap !== 1'b1) begin
                errors++;
                $display("FAIL degen_run cyc%0d: got cnt=%0d tc=%b wrap=%b want cnt=5 tc=1 wrap=1",
                         i, a.cnt, a.tc, a.wrap);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 'x;
            m_wrap[k] = 1'bx;
        end
        @(negedge clk);
        test_reset();
        test_wrap();
        test_mid_reset();
        test_reset_at_max();
        test_offset();
        test_degenerate();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
